pin_entry: RTL
==============

# pin_entry

Keypad/card front end that drives the bank-access FSM's `tx` and `paswrd` inputs. It detects card insertion and issues a one-cycle `tx` announcement. It then collects a single PIN digit from a strobed keypad and presents the digit on `paswrd` for a bounded window. It watches the returned `access` flag and locks out the terminal after repeated unsuccessful attempts.

## Interface
- `TIMEOUT`, 1000: idle cycles allowed in ENTRY before the session is abandoned.
- `HOLD_CYCLES`, 4: cycles a committed digit is driven on `paswrd`. Minimum 3, because downstream `access` rises about 2 cycles after a valid code.
- `MAX_TRIES`, 3: commits per card session before lockout. Range 1..15.
- `LOCK_CYCLES`, 50: lockout duration in cycles.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `card_in`  in  1  card-present level.
- `key_strb`  in  1  keypad strobe level; each rising edge is one keypress.
- `key_code`  in  4  key value, sampled on the strobe rising edge:
  - 0–9 = digit
  - 4'hA = ENTER
  - 4'hB = CLEAR
  - any other value = ignored
- `access`  in  1  grant flag from the downstream access FSM.
- `tx`  out  1  one-cycle session-start pulse to downstream.
- `paswrd`  out  4  code to downstream; 4'hF when nothing is presented.
- `locked`  out  1  high during lockout.
- `tries`  out  4  commits made in the current session.

## Operation
- Edge detectors:
  - `card_q` and `strb_q` hold the previous-cycle values; both reset to 0.
  - `card_rise` = `card_in & ~card_q`.
  - `key_ev` = `key_strb & ~strb_q`.
- Digit buffer `buf` (4 bits) plus flag `buf_vld`.
- All outputs are registered.
- States: IDLE, ANNOUNCE, ENTRY, PRESENT, LOCKED.
- IDLE
  - `paswrd`=F, `tx`=0.
  - On `card_rise`, go to ANNOUNCE.
  - Keys are ignored.
- ANNOUNCE
  - `tx`=1 for exactly this one cycle.
  - Clear `buf_vld` and the timer, then go to ENTRY.
- ENTRY (rules in priority order)
  - `card_in`=0: go to IDLE; `tries`←0.
  - `key_ev` with digit 0–9: `buf`←digit, `buf_vld`←1, timer←0. A later digit overwrites the earlier one.
  - `key_ev` with B: `buf_vld`←0, timer←0.
  - `key_ev` with A and `buf_vld`=1: go to PRESENT, `paswrd`←`buf`, `tries`←`tries`+1, hold counter←0.
  - `key_ev` with A and `buf_vld`=0: ignored, but timer←0.
  - No `key_ev`: timer increments. When timer reaches TIMEOUT−1, go to IDLE; `tries` is kept while the card stays in.
  - Any other `key_ev` (codes C–F): ignored; timer←0.
- PRESENT (rules in priority order)
  - `card_in`=0: go to IDLE, `paswrd`←F, `tries`←0.
  - `access`=1: go to IDLE, `paswrd`←F, `tries`←0. This is a successful session.
  - Hold counter reaches HOLD_CYCLES−1:
    - If `tries`==MAX_TRIES, go to LOCKED.
    - Otherwise go to ENTRY with `buf_vld`←0.
    - In both cases `paswrd`←F.
  - Keys are ignored.
- LOCKED
  - `locked`=1, `paswrd`=F; card and keys are ignored.
  - After LOCK_CYCLES cycles, go to IDLE with `tries`←0 and `locked`←0.
- A card still inserted when leaving LOCKED or a timeout does not start a session. Only a new `card_rise` does.
- Reset mid-operation overrides everything and returns to IDLE in the next cycle.

## Timing
- Reset values:
  - `tx`=0, `paswrd`=4'hF, `locked`=0, `tries`=0.
  - state=IDLE, `buf_vld`=0, all counters 0, `card_q`=`strb_q`=0.
- Card edge at cycle n is registered at edge n+1, so `card_rise` is seen in cycle n+1. `tx` is then high during cycle n+2 only.
- ENTER key edge sampled at edge k: `paswrd`=digit from k+1 through k+HOLD_CYCLES, and F from the next cycle onward.
- `access` is sampled at the rising edge. `paswrd` returns to F on the cycle after `access` is first seen high.
- A key strobe held high produces exactly one event. A new event needs `key_strb` to fall first.
- Card removal and a key event in the same cycle: removal wins.

## Test plan
- Reset, then raise `card_in` → `tx` is high for one cycle, 2 cycles after the edge. `paswrd`=F and `tries`=0 throughout.
- Card in, key 5, then key A → `paswrd`=5 for up to 4 cycles. Downstream model asserts `access` → `paswrd`=F, `tries`=0, state IDLE. No second `tx` while the card stays in.
- Card in, keys 3, 9, A → `paswrd`=9. No `access` → after 4 cycles `paswrd`=F, `tries`=1, back in ENTRY.
- Three commits of digit 2 with no `access` → `locked`=1 for 50 cycles, keys ignored, then `locked`=0 and `tries`=0.
- Keys A (empty buffer), then B after 7, then A → `paswrd` never leaves F.
- Timeout (bench TIMEOUT=20): card in and no keys → IDLE 20 cycles after ENTRY. Remove and reinsert the card → new `tx` pulse. Removing the card mid-PRESENT → `paswrd`=F on the next cycle.

Source files
------------

// File: rtl/pin_entry.sv
`default_nettype none
// ============================================================================
// Module   : pin_entry
// Purpose  : Keypad/card front end for the bank-access FSM. Detects card
//            insertion and announces a session with a one-cycle tx pulse,
//            collects a single PIN digit from a strobed keypad, presents it on
//            paswrd for a bounded window, and locks the terminal after
//            repeated unsuccessful commits.
// Ports    : clk          single clock, rising edge
//            rst          synchronous active-high reset
//            card_in_i    card-present level
//            key_strb_i   keypad strobe level (rising edge = one keypress)
//            key_code_i   key value: 0-9 digit, A enter, B clear, else ignored
//            access_i     grant flag from downstream access FSM
//            tx_o         one-cycle session-start pulse
//            paswrd_o     presented code, 4'hF when idle
//            locked_o     high during lockout
//            tries_o      commits made in the current session
// Revision : 1.0 - initial release
// ============================================================================
module pin_entry #(
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_in_i,
  input  logic       key_strb_i,
  input  logic [3:0] key_code_i,
  input  logic       access_i,
  output logic       tx_o,
  output logic [3:0] paswrd_o,
  output logic       locked_o,
  output logic [3:0] tries_o
);

  localparam int unsigned TMR_W  = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]        TRIES_MAX = 4'(MAX_TRIES);

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] CODE_NONE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ANNOUNCE = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_PRESENT  = 3'd3,
    ST_LOCKED   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                card_q, strb_q;
  logic [3:0]          dig_q, dig_d;
  logic                dig_vld_q, dig_vld_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic                tx_q, tx_d;
  logic [3:0]          paswrd_q, paswrd_d;
  logic                locked_q, locked_d;
  logic [3:0]          tries_q, tries_d;

  logic card_rise;
  logic key_ev;
  logic key_is_digit;

  assign card_rise    = card_in_i & ~card_q;
  assign key_ev       = key_strb_i & ~strb_q;
  assign key_is_digit = (key_code_i <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      card_q    <= 1'b0;
      strb_q    <= 1'b0;
      dig_q     <= 4'd0;
      dig_vld_q <= 1'b0;
      timer_q   <= '0;
      hold_q    <= '0;
      lock_q    <= '0;
      tx_q      <= 1'b0;
      paswrd_q  <= CODE_NONE;
      locked_q  <= 1'b0;
      tries_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      // Edge history is tracked in every state so a strobe or card level
      // held across a state change never produces a spurious event later.
      card_q    <= card_in_i;
      strb_q    <= key_strb_i;
      dig_q     <= dig_d;
      dig_vld_q <= dig_vld_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      tx_q      <= tx_d;
      paswrd_q  <= paswrd_d;
      locked_q  <= locked_d;
      tries_q   <= tries_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    dig_vld_d = dig_vld_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    lock_d    = lock_q;
    tx_d      = 1'b0;
    paswrd_d  = paswrd_q;
    locked_d  = locked_q;
    tries_d   = tries_q;

    case (state_q)
      ST_IDLE: begin
        paswrd_d = CODE_NONE;
        locked_d = 1'b0;
        // The try count survives a timeout only while the same card stays in.
        if (!card_in_i) begin
          tries_d = 4'd0;
        end
        if (card_rise) begin
          state_d = ST_ANNOUNCE;
        end
      end

      ST_ANNOUNCE: begin
        // Registered output: the pulse appears the cycle after ANNOUNCE.
        tx_d      = 1'b1;
        dig_vld_d = 1'b0;
        timer_d   = '0;
        state_d   = ST_ENTRY;
      end

      ST_ENTRY: begin
        if (!card_in_i) begin
          state_d = ST_IDLE;
          tries_d = 4'd0;
        end else if (key_ev) begin
          timer_d = '0;
          if (key_is_digit) begin
            dig_d     = key_code_i;
            dig_vld_d = 1'b1;
          end else if (key_code_i == KEY_CLEAR) begin
            dig_vld_d = 1'b0;
          end else if ((key_code_i == KEY_ENTER) && dig_vld_q) begin
            state_d  = ST_PRESENT;
            paswrd_d = dig_q;
            tries_d  = tries_q + 4'd1;
            hold_d   = '0;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_PRESENT: begin
        if (!card_in_i || access_i) begin
          state_d  = ST_IDLE;
          paswrd_d = CODE_NONE;
          tries_d  = 4'd0;
        end else if (hold_q == HOLD_LAST) begin
          paswrd_d = CODE_NONE;
          if (tries_q == TRIES_MAX) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            lock_d   = '0;
          end else begin
            state_d   = ST_ENTRY;
            dig_vld_d = 1'b0;
            timer_d   = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_LOCKED: begin
        paswrd_d = CODE_NONE;
        if (lock_q == LOCK_LAST) begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
          tries_d  = 4'd0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        paswrd_d = CODE_NONE;
        locked_d = 1'b0;
      end
    endcase
  end

  assign tx_o     = tx_q;
  assign paswrd_o = paswrd_q;
  assign locked_o = locked_q;
  assign tries_o  = tries_q;

endmodule
`default_nettype wire
